// File: rtl/line_fetch_sched.sv
// line_fetch_sched: per-line display fetch scheduler sharing one memory read
// port with a host requester. The display path has priority. The scheduler
// tracks the frame pointer, the line count, line completion and underrun.
// Optional feature: define LINE_FETCH_HOST_FAIR_EN to interleave one host
// transfer after each display word while a line is being fetched.
module line_fetch_sched #(
   parameter int V_RES          = 480,
   parameter int WORDS_PER_LINE = 20,
   parameter int ADDR_W         = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              h_next,
   input  logic              v_blank,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              host_grant,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_src,
   input  logic              mem_ack,
   output logic              line_ready,
   output logic              underrun
);

   localparam int LC_W = $clog2(V_RES + 1);
   localparam int WC_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [LC_W-1:0] V_RES_C   = LC_W'(V_RES);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [LC_W-1:0]   line_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic              pend_line;
   logic              abort;
   logic              fair_ret;
   logic              line_req;
   logic              xfer;

   // A line fetch is wanted only for active lines that still fit in the frame;
   // a transfer completes on any cycle where the request is accepted.
   // host_req seen during the host_grant cycle counts as a fresh request,
   // since the requester releases or replaces it as soon as it sees the grant.
   assign line_req = h_next & ~v_blank & (line_cnt < V_RES_C);
   assign xfer     = mem_req & mem_ack;

   // Scheduler state, pointers, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_src    <= 1'b0;
         host_grant <= 1'b0;
         line_ready <= 1'b0;
         underrun   <= 1'b0;
         ptr        <= '0;
         line_cnt   <= '0;
         word_cnt   <= '0;
         pend_line  <= 1'b0;
         abort      <= 1'b0;
         fair_ret   <= 1'b0;
      end else begin
         host_grant <= 1'b0;
         line_ready <= 1'b0;

         if (frame_start) begin
            ptr       <= base_addr;
            line_cnt  <= '0;
            word_cnt  <= '0;
            pend_line <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (frame_start) begin
                  mem_req <= 1'b0;
               end else if (pend_line | line_req) begin
                  state     <= DISP;
                  mem_req   <= 1'b1;
                  mem_addr  <= ptr;
                  mem_src   <= 1'b0;
                  pend_line <= 1'b0;
               end else if (host_req) begin
                  state    <= HOST;
                  mem_req  <= 1'b1;
                  mem_addr <= host_addr;
                  mem_src  <= 1'b1;
               end
            end

            DISP: begin
               if (line_req & ~frame_start) begin
                  underrun <= 1'b1;
               end
               if (frame_start & ~xfer) begin
                  abort <= 1'b1;
               end
               if (xfer) begin
                  if (abort | frame_start) begin
                     state    <= IDLE;
                     mem_req  <= 1'b0;
                     mem_src  <= 1'b0;
                     abort    <= 1'b0;
                     word_cnt <= '0;
                  end else if (word_cnt == LAST_WORD) begin
                     state      <= IDLE;
                     mem_req    <= 1'b0;
                     ptr        <= ptr + ADDR_W'(1);
                     word_cnt   <= '0;
                     line_ready <= 1'b1;
                     if (line_cnt < V_RES_C) begin
                        line_cnt <= line_cnt + LC_W'(1);
                     end
                  end else begin
                     ptr      <= ptr + ADDR_W'(1);
                     word_cnt <= word_cnt + WC_W'(1);
`ifdef LINE_FETCH_HOST_FAIR_EN
                     if (host_req) begin
                        state    <= HOST;
                        fair_ret <= 1'b1;
                        mem_addr <= host_addr;
                        mem_src  <= 1'b1;
                     end else begin
                        mem_addr <= ptr + ADDR_W'(1);
                     end
`else
                     mem_addr <= ptr + ADDR_W'(1);
`endif
                  end
               end
            end

            HOST: begin
               if (line_req & ~frame_start) begin
                  if (fair_ret) begin
                     underrun <= 1'b1;
                  end else begin
                     pend_line <= 1'b1;
                  end
               end
               if (frame_start & ~xfer) begin
                  abort <= 1'b1;
               end
               if (xfer) begin
                  host_grant <= 1'b1;
                  abort      <= 1'b0;
                  fair_ret   <= 1'b0;
                  if (abort | frame_start) begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                     mem_src <= 1'b0;
                  end else if (fair_ret) begin
                     state    <= DISP;
                     mem_addr <= ptr;
                     mem_src  <= 1'b0;
                  end else if (pend_line | line_req) begin
                     state     <= DISP;
                     mem_addr  <= ptr;
                     mem_src   <= 1'b0;
                     pend_line <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     mem_req <= 1'b0;
                     mem_src <= 1'b0;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_fetch_sched.sv
// tb_line_fetch_sched: table-driven line fetches plus hand-written corner
// sequences, with a scoreboard queue of expected memory transfers.
module tb_line_fetch_sched;

   localparam int WORDS = 20;
   localparam int VRES  = 480;

   logic        clk = 1'b0;
   logic        reset;
   logic        h_next;
   logic        v_blank;
   logic        frame_start;
   logic [23:0] base_addr;
   logic        host_req;
   logic [23:0] host_addr;
   logic        host_grant;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic        mem_src;
   logic        mem_ack;
   logic        line_ready;
   logic        underrun;

   typedef struct {
      logic [23:0] addr;
      logic        src;
      logic        last;
   } exp_t;

   typedef struct {
      logic        fs;
      logic [23:0] base;
      logic        vb;
      int          words;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[6];
   logic [23:0] host_list[3];
   int          host_n   = 0;
   int          host_idx = 0;
   logic [23:0] model_ptr;
   int          total = 0;
   int          bad   = 0;

   line_fetch_sched dut (
      .clk         (clk),
      .reset       (reset),
      .h_next      (h_next),
      .v_blank     (v_blank),
      .frame_start (frame_start),
      .base_addr   (base_addr),
      .host_req    (host_req),
      .host_addr   (host_addr),
      .host_grant  (host_grant),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_src     (mem_src),
      .mem_ack     (mem_ack),
      .line_ready  (line_ready),
      .underrun    (underrun)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   // One clock: score any transfer accepted at this edge, then check pulses.
   task automatic cycle();
      exp_t e;
      bit   popped;
      popped = 1'b0;
      e = '{addr: 24'h0, src: 1'b0, last: 1'b0};
      if (mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_xfer: got addr 0x%0h src %0d want no transfer", mem_addr, mem_src);
         end else begin
            e = exp_q.pop_front();
            popped = 1'b1;
            checkOutput("mem_addr", mem_addr, e.addr);
            checkOutput("mem_src", mem_src, e.src);
         end
      end
      @(posedge clk);
      #1;
      checkOutput("line_ready", line_ready, popped && e.last);
      checkOutput("host_grant", host_grant, popped && e.src);
      if (host_grant && host_idx < host_n) begin
         host_idx++;
         if (host_idx < host_n) begin
            host_addr = host_list[host_idx];
         end else begin
            host_req = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      total++;
      if (exp_q.size() > 0) begin
         bad++;
         $display("[TB] FAIL drain_timeout: %0d entries left want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pushDisp(input logic [23:0] start, input int n);
      logic [23:0] a;
      for (int i = 0; i < n; i++) begin
         a = start + 24'(i);
         exp_q.push_back('{addr: a, src: 1'b0, last: (i == WORDS - 1)});
      end
   endtask

   task automatic pushHost(input logic [23:0] a);
      exp_q.push_back('{addr: a, src: 1'b1, last: 1'b0});
   endtask

   task automatic frameStart(input logic [23:0] base);
      frame_start = 1'b1;
      base_addr   = base;
      cycle();
      frame_start = 1'b0;
      model_ptr   = base;
   endtask

   task automatic applyStimulus(input vec_t v);
      mem_ack = 1'b1;
      if (v.fs) begin
         frameStart(v.base);
      end
      pushDisp(model_ptr, v.words);
      h_next  = 1'b1;
      v_blank = v.vb;
      cycle();
      h_next  = 1'b0;
      v_blank = 1'b0;
      checkOutput("req_latency", mem_req, (v.words != 0));
      drain(60);
      model_ptr = model_ptr + 24'(v.words);
      idle(3);
      checkOutput("idle_after_line", mem_req, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      h_next      = 1'b0;
      v_blank     = 1'b0;
      frame_start = 1'b0;
      base_addr   = 24'h0;
      host_req    = 1'b0;
      host_addr   = 24'h0;
      mem_ack     = 1'b0;
      model_ptr   = 24'h0;

      vecs[0] = '{fs: 1'b1, base: 24'h000100, vb: 1'b0, words: WORDS};
      vecs[1] = '{fs: 1'b0, base: 24'h000000, vb: 1'b0, words: WORDS};
      vecs[2] = '{fs: 1'b0, base: 24'h000000, vb: 1'b1, words: 0};
      vecs[3] = '{fs: 1'b1, base: 24'h002000, vb: 1'b0, words: WORDS};
      vecs[4] = '{fs: 1'b1, base: 24'hFFFFF6, vb: 1'b0, words: WORDS};
      vecs[5] = '{fs: 1'b0, base: 24'h000000, vb: 1'b1, words: 0};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_mem_req", mem_req, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, 24'h0);
      checkOutput("rst_mem_src", mem_src, 1'b0);
      checkOutput("rst_host_grant", host_grant, 1'b0);
      checkOutput("rst_line_ready", line_ready, 1'b0);
      checkOutput("rst_underrun", underrun, 1'b0);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] host arbitration during a line fetch");
      host_list[0] = 24'hABC000;
      host_list[1] = 24'hABC010;
      host_list[2] = 24'hABC020;
      mem_ack = 1'b1;
      frameStart(24'h000100);
`ifdef LINE_FETCH_HOST_FAIR_EN
      for (int i = 0; i < WORDS; i++) begin
         exp_q.push_back('{addr: 24'h000100 + 24'(i), src: 1'b0, last: (i == WORDS - 1)});
         if (i < 3) pushHost(host_list[i]);
      end
`else
      pushDisp(24'h000100, WORDS);
      for (int i = 0; i < 3; i++) pushHost(host_list[i]);
`endif
      h_next = 1'b1;
      cycle();
      h_next    = 1'b0;
      host_n    = 3;
      host_idx  = 0;
      host_addr = host_list[0];
      host_req  = 1'b1;
      drain(100);
      idle(4);
      checkOutput("host_done_req", host_req, 1'b0);
      checkOutput("host_idle", mem_req, 1'b0);
      host_n = 0;

      $display("[TB] stalled line and underrun");
      frameStart(24'h003000);
      pushDisp(24'h003000, WORDS);
      mem_ack = 1'b0;
      h_next  = 1'b1;
      cycle();
      h_next = 1'b0;
      idle(30);
      checkOutput("stall_req", mem_req, 1'b1);
      checkOutput("stall_addr", mem_addr, 24'h003000);
      checkOutput("pre_underrun", underrun, 1'b0);
      h_next = 1'b1;
      cycle();
      h_next = 1'b0;
      checkOutput("underrun_set", underrun, 1'b1);
      mem_ack = 1'b1;
      drain(40);
      idle(30);
      checkOutput("underrun_sticky", underrun, 1'b1);

      $display("[TB] reset during a transfer");
      mem_ack = 1'b0;
      h_next  = 1'b1;
      cycle();
      h_next = 1'b0;
      idle(2);
      checkOutput("pre_reset_req", mem_req, 1'b1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checkOutput("reset_mid_req", mem_req, 1'b0);
      checkOutput("reset_clears_underrun", underrun, 1'b0);
      mem_ack = 1'b1;
      idle(5);

      $display("[TB] frame line limit");
      frameStart(24'h000000);
      for (int l = 0; l < VRES; l++) begin
         pushDisp(model_ptr, WORDS);
         h_next = 1'b1;
         cycle();
         h_next = 1'b0;
         drain(40);
         model_ptr = model_ptr + 24'(WORDS);
      end
      h_next = 1'b1;
      cycle();
      h_next = 1'b0;
      checkOutput("sat_no_req", mem_req, 1'b0);
      idle(10);
      applyStimulus('{fs: 1'b1, base: 24'h002000, vb: 1'b0, words: WORDS});

      $display("[TB] frame start with a transfer outstanding");
      frameStart(24'h000500);
      pushDisp(24'h000500, 4);
      h_next = 1'b1;
      cycle();
      h_next = 1'b0;
      idle(3);
      mem_ack = 1'b0;
      frame_start = 1'b1;
      base_addr   = 24'h000900;
      cycle();
      frame_start = 1'b0;
      model_ptr   = 24'h000900;
      idle(4);
      checkOutput("abort_hold_req", mem_req, 1'b1);
      checkOutput("abort_hold_addr", mem_addr, 24'h000503);
      mem_ack = 1'b1;
      drain(5);
      checkOutput("abort_released", mem_req, 1'b0);
      idle(10);
      applyStimulus('{fs: 1'b0, base: 24'h000000, vb: 1'b0, words: WORDS});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
